load_return_mux: RTL and testbench
==================================

Name: load_return_mux

Overview:
- Parametrised successor to the core's load-data select path.
- Accepts one load request at a time, tagged with a region code (upper address nibble), byte offset and funct3.
- Waits for the selected source (DMEM, BIOS, IO, or more) to return read data, then extracts, sign- or zero-extends and registers the result.
- Sits between the memory-stage address decode and writeback, and replaces the purely combinational select with a valid/ready handshake plus a per-request timeout.

Parameters:
- NUM_SRC, 4, number of read-data sources (min 2).
- SEL_W, 4, width of the region code.
- SRC_CODES, {4'b1000,4'b0100,4'b0010,4'b0001}, packed NUM_SRC×SEL_W code per source; index 0 is the LSB slice.
- DEFAULT_SRC, 0, source index used when the code matches no entry.
- TIMEOUT, 15, maximum WAIT cycles before the request is aborted (1..255).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  load request present
- req_ready  out  1  block can accept a request
- req_sel  in  SEL_W  region code
- req_off  in  2  byte offset (addr[1:0])
- req_funct3  in  3  RV32I load funct3
- src_rdata  in  NUM_SRC×32  packed read data; source i at [32i+31:32i]
- src_rvalid  in  NUM_SRC  source i data valid (tie high for fixed 1-cycle BRAM)
- resp_valid  out  1  result available
- resp_ready  in  1  writeback consumes result
- resp_data  out  32  extended load result
- resp_err  out  1  misaligned, illegal funct3 or timeout
- resp_src  out  clog2(NUM_SRC)  source index that served the request

Behaviour:
- **States:** IDLE, WAIT, RESP. Reset puts the FSM in IDLE and clears resp_valid, resp_data, resp_err, resp_src and the timeout counter.
- **req_ready:** high in IDLE, and in RESP when resp_ready=1. This gives single-outstanding operation with zero-bubble turnaround.
- **Accept:** on req_valid&&req_ready, latch the decoded source index, req_off and req_funct3, clear the counter, and go to WAIT. If RESP is being consumed in the same cycle, drop resp_valid and go to WAIT.
- **Decode:** the lowest index whose SRC_CODES slice equals req_sel wins; no match selects DEFAULT_SRC.
- **WAIT with src_rvalid[idx]=1:** register the extracted data, set resp_valid=1, go to RESP.
  - Tied-high source: accept at cycle N, resp_valid at N+2.
- **WAIT with src_rvalid[idx]=0:** increment the counter.
  - When the counter reaches TIMEOUT, go to RESP with resp_data=0 and resp_err=1.
  - src_rvalid on other indices is ignored.
- **RESP:** resp_data, resp_err and resp_src hold stable while resp_valid && !resp_ready. On resp_ready with no new request, go to IDLE.
- **Extraction:**
  - byte = rdata[8·off +: 8]; half = rdata[16·off[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the full word.
- **Error cases:** resp_err=1 and resp_data=0 for any of:
  - LH/LHU with off[0]=1;
  - LW with off≠0;
  - funct3 in {011,110,111}.
  - The block still waits for src_rvalid so the source handshake completes.
- **Timeout timing:** a timeout response and a late src_rvalid never both take effect. src_rvalid arriving after the timeout is dropped.
- **Reset mid-WAIT or mid-RESP:** asynchronous return to IDLE and all outputs cleared. The pending request is lost; the core flushes on reset anyway.

Decomposition:
- Shared package (core_pkg):
  - funct3 load encodings (LB=000, LH=001, LW=010, LBU=100, LHU=101);
  - default region codes (REG_DMEM, REG_BIOS, REG_IO);
  - FSM state enum.
- Sub-module load_extend: purely combinational (word, off, funct3) -> (data, misalign_err). Reused by the store-data path's mirror logic.

Test Plan:
- Tied-high DMEM (code 0001, src 3) holds 32'h8765_4321; LW off=0 accepted at cycle 0 → resp_valid at cycle 2, resp_data=32'h8765_4321, resp_src=3, resp_err=0.
- Same word, LB off=3 → 32'hFFFF_FF87; LBU off=3 → 32'h0000_0087; LH off=2 → 32'hFFFF_8765; LHU off=0 → 32'h0000_4321.
- IO source (code 1000) asserts rvalid 5 cycles after accept with 32'hCAFE_0001 → resp_valid one cycle later with that data. With resp_ready held low for 3 cycles, the data stays stable and req_ready=0.
- IO never asserts rvalid, TIMEOUT=15 → resp_valid 16 cycles after accept, resp_data=0, resp_err=1. A later stray rvalid causes no extra response.
- Unmapped code 4'b1111 → served by DEFAULT_SRC. LW off=2 → resp_err=1, resp_data=0. funct3=011 → resp_err=1.
- Back-to-back requests with resp_ready=1 and tied-high sources → one response every 2 cycles. rst_n pulled low during WAIT → resp_valid=0 immediately, FSM in IDLE, req_ready=1 after release.

Source files
------------

// File: rtl/load_return_mux_pkg.sv
// Shared definitions for the load-return path: RV32I load funct3 codes,
// default region codes and the FSM state encoding.
package load_return_mux_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [3:0] REG_DMEM = 4'b0001;
    localparam logic [3:0] REG_BIOS = 4'b0100;
    localparam logic [3:0] REG_IO   = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/load_return_mux_if.sv
// Request, source read-data and response bundle of the load-return mux.
interface load_return_mux_if #(
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 4
);
    localparam int SRC_W = $clog2(NUM_SRC);

    // Both req_* and resp_* transfer on a cycle where valid && ready; a
    // producer holds its payload stable until that cycle, and src_rvalid is
    // a one-shot qualifier with no ready of its own.
    logic                   req_valid;
    logic                   req_ready;
    logic [SEL_W-1:0]       req_sel;
    logic [1:0]             req_off;
    logic [2:0]             req_funct3;
    logic [NUM_SRC*32-1:0]  src_rdata;
    logic [NUM_SRC-1:0]     src_rvalid;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [31:0]            resp_data;
    logic                   resp_err;
    logic [SRC_W-1:0]       resp_src;

    modport master (
        output req_valid, req_sel, req_off, req_funct3, src_rdata, src_rvalid, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_err, resp_src
    );

    modport slave (
        input  req_valid, req_sel, req_off, req_funct3, src_rdata, src_rvalid, resp_ready,
        output req_ready, resp_valid, resp_data, resp_err, resp_src
    );

endinterface

// File: rtl/load_return_mux_load_extend.sv
// Combinational byte/half/word extraction with sign or zero extension.
// o_err flags misaligned halves/words and funct3 codes that are not loads.
module load_extend
    import load_return_mux_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data,
    output logic        o_err
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[{i_off, 3'b000} +: 8];
    assign w_half = i_word[{i_off[1], 4'b0000} +: 16];

    always_comb begin
        o_data = '0;
        o_err  = 1'b0;
        case (i_funct3)
            F3_LB:  o_data = {{24{w_byte[7]}}, w_byte};
            F3_LBU: o_data = {24'd0, w_byte};
            F3_LH: begin
                if (i_off[0]) o_err  = 1'b1;
                else          o_data = {{16{w_half[15]}}, w_half};
            end
            F3_LHU: begin
                if (i_off[0]) o_err  = 1'b1;
                else          o_data = {16'd0, w_half};
            end
            F3_LW: begin
                if (i_off != 2'd0) o_err  = 1'b1;
                else               o_data = i_word;
            end
            default: o_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/load_return_mux.sv
// Single-outstanding load return path: decodes the region code to a source,
// waits (bounded) for its read data, then extends and registers the result.
module load_return_mux
    import load_return_mux_pkg::*;
#(
    parameter int                         NUM_SRC     = 4,
    parameter int                         SEL_W       = 4,
    parameter logic [NUM_SRC*SEL_W-1:0]   SRC_CODES   = {4'b1000, 4'b0100, 4'b0010, 4'b0001},
    parameter int                         DEFAULT_SRC = 0,
    parameter int                         TIMEOUT     = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    load_return_mux_if.slave   bus,
    output state_t             o_dbg_state
);

    localparam int SRC_W = $clog2(NUM_SRC);

    state_t             r_state;
    state_t             w_next;
    logic [SRC_W-1:0]   r_idx;
    logic [1:0]         r_off;
    logic [2:0]         r_funct3;
    logic [7:0]         r_cnt;
    logic               r_resp_valid;
    logic [31:0]        r_resp_data;
    logic               r_resp_err;
    logic [SRC_W-1:0]   r_resp_src;

    logic [SRC_W-1:0]   w_dec_idx;
    logic               w_accept;
    logic               w_src_valid;
    logic [31:0]        w_word;
    logic [31:0]        w_ext_data;
    logic               w_ext_err;
    logic               w_load;
    logic               w_timeout;

    assign bus.req_ready  = (r_state == ST_IDLE) || ((r_state == ST_RESP) && bus.resp_ready);
    assign w_accept       = bus.req_valid && bus.req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_data  = r_resp_data;
    assign bus.resp_err   = r_resp_err;
    assign bus.resp_src   = r_resp_src;
    assign o_dbg_state    = r_state;

    // Descending scan so the lowest matching index is the one that sticks.
    always_comb begin
        w_dec_idx = SRC_W'(DEFAULT_SRC);
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (SRC_CODES[i*SEL_W +: SEL_W] == bus.req_sel) w_dec_idx = SRC_W'(i);
        end
    end

    assign w_src_valid = bus.src_rvalid[r_idx];
    assign w_word      = bus.src_rdata[{r_idx, 5'b00000} +: 32];

    load_extend u_extend (
        .i_word   (w_word),
        .i_off    (r_off),
        .i_funct3 (r_funct3),
        .o_data   (w_ext_data),
        .o_err    (w_ext_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Data arriving in the last WAIT cycle still wins over the timeout.
    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_WAIT;
            ST_WAIT: begin
                if (w_src_valid) begin
                    w_next = ST_RESP;
                    w_load = 1'b1;
                end else if (r_cnt == 8'(TIMEOUT - 1)) begin
                    w_next    = ST_RESP;
                    w_timeout = 1'b1;
                end
            end
            ST_RESP: if (bus.resp_ready) w_next = w_accept ? ST_WAIT : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx        <= '0;
            r_off        <= '0;
            r_funct3     <= '0;
            r_cnt        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
            r_resp_src   <= '0;
        end else begin
            if (w_accept) begin
                r_idx    <= w_dec_idx;
                r_off    <= bus.req_off;
                r_funct3 <= bus.req_funct3;
                r_cnt    <= '0;
            end else if ((r_state == ST_WAIT) && !w_src_valid) begin
                r_cnt <= r_cnt + 8'd1;
            end

            if (w_load) begin
                r_resp_valid <= 1'b1;
                r_resp_data  <= w_ext_data;
                r_resp_err   <= w_ext_err;
                r_resp_src   <= r_idx;
            end else if (w_timeout) begin
                r_resp_valid <= 1'b1;
                r_resp_data  <= '0;
                r_resp_err   <= 1'b1;
                r_resp_src   <= r_idx;
            end else if ((r_state == ST_RESP) && bus.resp_ready) begin
                r_resp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_load_return_mux.sv
// Randomized bench for load_return_mux: directed loads, latency/timeout,
// back-to-back scoreboard and asynchronous reset mid-transaction.
module tb_load_return_mux;
  import load_return_mux_pkg::*;

  localparam int NUM_SRC     = 4;
  localparam int SEL_W       = 4;
  localparam int TIMEOUT     = 15;
  localparam int DEFAULT_SRC = 0;
  // Source 0 = IO (1000), source 3 = DMEM (0001).
  localparam logic [15:0] TB_CODES = {4'b0001, 4'b0010, 4'b0100, 4'b1000};

  logic clk;
  logic rst_n;
  state_t dbg_state;
  int n_tests;
  int n_fail;
  logic [31:0] src_word[4];
  int code_of[4] = '{8, 4, 2, 1};

  load_return_mux_if #(.NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) bus ();

  load_return_mux #(
    .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .SRC_CODES(TB_CODES),
    .DEFAULT_SRC(DEFAULT_SRC), .TIMEOUT(TIMEOUT)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model
  function automatic int ref_idx(input logic [3:0] sel);
    for (int i = 0; i < 4; i++) if (code_of[i] == int'(sel)) return i;
    return DEFAULT_SRC;
  endfunction

  function automatic logic [32:0] ref_load(input logic [31:0] word, input int off, input logic [2:0] f3);
    int unsigned b;
    int unsigned h;
    b = (word >> (8 * off)) & 32'hFF;
    h = (word >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'b000: return {1'b0, (b >= 128) ? 32'(b) - 32'd256 : 32'(b)};
      3'b100: return {1'b0, 32'(b)};
      3'b001: begin
        if (off % 2 != 0) return {1'b1, 32'd0};
        return {1'b0, (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h)};
      end
      3'b101: begin
        if (off % 2 != 0) return {1'b1, 32'd0};
        return {1'b0, 32'(h)};
      end
      3'b010: begin
        if (off != 0) return {1'b1, 32'd0};
        return {1'b0, word};
      end
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  task automatic load_rdata();
    for (int i = 0; i < NUM_SRC; i++) bus.src_rdata[32*i +: 32] = src_word[i];
  endtask

  // driver: one request; lat=0 means tied-high sources, otherwise rvalid
  // pulses lat cycles after accept; hold = cycles resp_ready stays low.
  task automatic run_req(input logic [3:0] sel, input logic [1:0] off, input logic [2:0] f3,
                         input int lat, input int hold);
    int idx;
    int got_lat;
    int exp_lat;
    logic [32:0] exp_r;
    idx   = ref_idx(sel);
    exp_r = ref_load(src_word[idx], int'(off), f3);
    if (lat == 0)            exp_lat = 2;
    else if (lat <= TIMEOUT) exp_lat = lat + 1;
    else begin
      exp_lat = TIMEOUT + 1;
      exp_r   = {1'b1, 32'd0};
    end
    bus.resp_ready = (hold == 0);
    bus.src_rvalid = (lat == 0) ? 4'hF : 4'h0;
    bus.req_valid  = 1'b1;
    bus.req_sel    = sel;
    bus.req_off    = off;
    bus.req_funct3 = f3;
    check("req_ready_idle", bus.req_ready, 1);
    @(posedge clk);
    got_lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) bus.req_valid = 1'b0;
      if (bus.resp_valid) begin
        got_lat = k;
        break;
      end
      if (lat != 0)
        bus.src_rvalid = (4'($urandom) & ~(4'b1 << idx)) | ((k == lat) ? (4'b1 << idx) : 4'b0);
    end
    check("latency", got_lat, exp_lat);
    check("resp_data", bus.resp_data, exp_r[31:0]);
    check("resp_err", bus.resp_err, exp_r[32]);
    check("resp_src", bus.resp_src, idx);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (lat != 0) bus.src_rvalid = 4'($urandom);
      check("hold_valid", bus.resp_valid, 1);
      check("hold_data", {bus.resp_err, bus.resp_src, bus.resp_data}, {exp_r[32], 2'(idx), exp_r[31:0]});
      check("hold_req_ready", bus.req_ready, 0);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    check("drained", bus.resp_valid, 0);
    bus.src_rvalid = 4'h0;
  endtask

  // scoreboard run: continuous requests against tied-high sources
  task automatic b2b(input int n_cyc);
    logic [34:0] exp_q[$];
    logic [34:0] item;
    logic [32:0] r;
    int last;
    int idx;
    bit acc;
    last = -1;
    bus.src_rvalid = 4'hF;
    bus.resp_ready = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_sel    = 4'($urandom);
    bus.req_off    = 2'($urandom);
    bus.req_funct3 = 3'($urandom);
    for (int c = 0; c < n_cyc + 6; c++) begin
      if (bus.resp_valid && bus.resp_ready) begin
        if (exp_q.size() == 0) check("b2b_unexpected", 1, 0);
        else begin
          item = exp_q.pop_front();
          check("b2b_resp", {bus.resp_err, bus.resp_src, bus.resp_data}, item);
        end
        if (last >= 0) check("b2b_gap", c - last, 2);
        last = c;
      end
      acc = bus.req_valid && bus.req_ready;
      if (acc) begin
        idx = ref_idx(bus.req_sel);
        r   = ref_load(src_word[idx], int'(bus.req_off), bus.req_funct3);
        exp_q.push_back({r[32], 2'(idx), r[31:0]});
      end
      @(negedge clk);
      if (acc) begin
        bus.req_valid  = (c < n_cyc);
        bus.req_sel    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(code_of[$urandom_range(0, 3)]);
        bus.req_off    = 2'($urandom);
        bus.req_funct3 = ($urandom_range(0, 1) == 0) ? 3'b010 : 3'($urandom);
        if (bus.req_funct3 == 3'b010 && $urandom_range(0, 1) == 0) bus.req_off = 2'd0;
      end
    end
    bus.req_valid = 1'b0;
    check("b2b_drain", exp_q.size(), 0);
    bus.src_rvalid = 4'h0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_sel    = '0;
    bus.req_off    = '0;
    bus.req_funct3 = '0;
    bus.src_rvalid = '0;
    bus.resp_ready = 1'b1;
    src_word[0] = 32'hCAFE_0001;
    src_word[1] = $urandom;
    src_word[2] = $urandom;
    src_word[3] = 32'h8765_4321;
    load_rdata();
    repeat (3) @(negedge clk);
    check("rst_valid", bus.resp_valid, 0);
    check("rst_data", bus.resp_data, 0);
    check("rst_err", bus.resp_err, 0);
    check("rst_src", bus.resp_src, 0);
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_req_ready", bus.req_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // DMEM tied-high extraction cases
    run_req(4'b0001, 2'd0, F3_LW, 0, 0);
    run_req(4'b0001, 2'd3, F3_LB, 0, 0);
    run_req(4'b0001, 2'd3, F3_LBU, 0, 0);
    run_req(4'b0001, 2'd2, F3_LH, 0, 0);
    run_req(4'b0001, 2'd0, F3_LHU, 0, 0);
    // IO late data with backpressure, then timeout
    run_req(4'b1000, 2'd0, F3_LW, 5, 3);
    run_req(4'b1000, 2'd0, F3_LW, 99, 0);
    bus.src_rvalid = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stray_rvalid", bus.resp_valid, 0);
    end
    bus.src_rvalid = 4'h0;
    // unmapped code and error encodings
    run_req(4'b1111, 2'd0, F3_LW, 0, 0);
    run_req(4'b0001, 2'd2, F3_LW, 0, 0);
    run_req(4'b0001, 2'd0, 3'b011, 0, 0);
    run_req(4'b0001, 2'd1, F3_LHU, 2, 1);
    run_req(4'b0010, 2'd1, F3_LBU, TIMEOUT, 0);

    // randomized single requests
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < NUM_SRC; i++) src_word[i] = $urandom;
      load_rdata();
      run_req(($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'(code_of[$urandom_range(0, 3)]),
              2'($urandom), 3'($urandom), $urandom_range(0, 18), $urandom_range(0, 2));
    end

    b2b(40);

    // reset while waiting on a silent source
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_sel    = 4'b1000;
    bus.req_off    = 2'd0;
    bus.req_funct3 = F3_LW;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_wait", dbg_state, ST_WAIT);
    #2 rst_n = 1'b0;
    #1;
    check("rst_wait_valid", bus.resp_valid, 0);
    check("rst_wait_state", dbg_state, ST_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_wait_ready", bus.req_ready, 1);

    // reset while a response is held
    bus.src_rvalid = 4'hF;
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_sel    = 4'b0001;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_resp", bus.resp_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_data", bus.resp_data, 0);
    check("rst_resp_state", dbg_state, ST_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    bus.resp_ready = 1'b1;
    bus.src_rvalid = 4'h0;
    @(negedge clk);
    check("post_rst_ready", bus.req_ready, 1);
    check("post_rst_valid", bus.resp_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
